// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants and grant-source encoding for the register-bank port arbiter.
package regfile_port_arbiter_pkg;

    localparam int RF_NREG         = 16;
    localparam int RF_AW           = 4;
    localparam int RF_DW           = 32;
    localparam int RF_STARVE_LIMIT = 3;

    // Which requester owns the bank port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WB0  = 2'd2,
        GNT_WB1  = 2'd3
    } gnt_src_e;

    function automatic logic gnt_is_write(gnt_src_e src);
        return (src == GNT_WB0) || (src == GNT_WB1);
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester, scoreboard and bank-side signals of the register-bank port arbiter.
// The master side is the pipeline plus the bank; the slave side is the arbiter.
interface regfile_port_arbiter_if
    import regfile_port_arbiter_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) ();

    // decode read requester
    logic            rd_req;
    logic [AW-1:0]   rd_a_addr;
    logic [AW-1:0]   rd_b_addr;
    logic            rd_gnt;
    logic            rd_valid;
    logic [DW-1:0]   rd_a_data;
    logic [DW-1:0]   rd_b_data;

    // writeback requesters (0 = ALU, 1 = load)
    logic            wb0_req;
    logic [AW-1:0]   wb0_addr;
    logic [DW-1:0]   wb0_data;
    logic            wb0_gnt;
    logic            wb1_req;
    logic [AW-1:0]   wb1_addr;
    logic [DW-1:0]   wb1_data;
    logic            wb1_gnt;

    // issue-side scoreboard
    logic            sb_set;
    logic [AW-1:0]   sb_set_addr;
    logic [NREG-1:0] sb_busy;

    // register bank control and read outputs
    logic            rf_hab_escrita;
    logic [AW-1:0]   rf_sel_c_a;
    logic [AW-1:0]   rf_sel_b;
    logic [DW-1:0]   rf_wc;
    logic [DW-1:0]   rf_a_q;
    logic [DW-1:0]   rf_b_q;

    modport master (
        output rd_req, rd_a_addr, rd_b_addr,
        output wb0_req, wb0_addr, wb0_data,
        output wb1_req, wb1_addr, wb1_data,
        output sb_set, sb_set_addr,
        output rf_a_q, rf_b_q,
        input  rd_gnt, rd_valid, rd_a_data, rd_b_data,
        input  wb0_gnt, wb1_gnt, sb_busy,
        input  rf_hab_escrita, rf_sel_c_a, rf_sel_b, rf_wc
    );

    modport slave (
        input  rd_req, rd_a_addr, rd_b_addr,
        input  wb0_req, wb0_addr, wb0_data,
        input  wb1_req, wb1_addr, wb1_data,
        input  sb_set, sb_set_addr,
        input  rf_a_q, rf_b_q,
        output rd_gnt, rd_valid, rd_a_data, rd_b_data,
        output wb0_gnt, wb1_gnt, sb_busy,
        output rf_hab_escrita, rf_sel_c_a, rf_sel_b, rf_wc
    );

endinterface

// File: rtl/regfile_port_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue, cleared
// when the matching write leaves the bank port. Set beats clear on collision.
module regfile_scoreboard
    import regfile_port_arbiter_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int AW   = RF_AW
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_set,
    input  logic [AW-1:0]   i_set_addr,
    input  logic            i_clr,
    input  logic [AW-1:0]   i_clr_addr,
    input  logic [AW-1:0]   i_look_a,
    input  logic [AW-1:0]   i_look_b,
    output logic [NREG-1:0] o_busy,
    output logic            o_busy_a,
    output logic            o_busy_b
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            logic w_set_hit;
            logic w_clr_hit;
            assign w_set_hit = i_set && (i_set_addr == AW'(gi));
            assign w_clr_hit = i_clr && (i_clr_addr == AW'(gi));
            // set has priority so a reissue in the write's last cycle is not lost
            assign w_busy_next[gi] = w_set_hit ? 1'b1 :
                                     w_clr_hit ? 1'b0 : r_busy[gi];
        end
    endgenerate

    // busy vector register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy   = r_busy;
    assign o_busy_a = r_busy[i_look_a];
    assign o_busy_b = r_busy[i_look_b];

endmodule

// File: rtl/regfile_port_arbiter.sv
// Schedules the single shared write/read-A port of the 16x32 register bank
// among one decode reader and two writeback writers. Port values are
// registered so the bank, which samples on the falling edge, sees them stable
// for the whole grant cycle.
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int NREG         = RF_NREG,
    parameter int AW           = RF_AW,
    parameter int DW           = RF_DW,
    parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
    input logic                   i_clock,
    input logic                   i_reset,
    regfile_port_arbiter_if.slave bus
);

    localparam int              SCW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0]  SC_MAX = SCW'(STARVE_LIMIT);

    // registered grant / port state
    logic           r_rd_gnt;
    logic           r_wb0_gnt;
    logic           r_wb1_gnt;
    logic           r_rd_valid;
    logic           r_hab;
    logic [AW-1:0]  r_sel_c_a;
    logic [AW-1:0]  r_sel_b;
    logic [DW-1:0]  r_wc;
    logic           r_rr_ptr;      // 0: wb0 preferred, 1: wb1 preferred
    logic [SCW-1:0] r_starve_cnt;

    // combinational arbitration
    logic           w_rd_eff;
    logic           w_rd_elig;
    logic           w_wb0_eff;
    logic           w_wb1_eff;
    logic           w_busy_a;
    logic           w_busy_b;
    logic [NREG-1:0] w_sb_busy;
    gnt_src_e       w_win;
    logic [SCW-1:0] w_starve_next;

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_set      (bus.sb_set),
        .i_set_addr (bus.sb_set_addr),
        .i_clr      (r_wb0_gnt | r_wb1_gnt),
        .i_clr_addr (r_sel_c_a),
        .i_look_a   (bus.rd_a_addr),
        .i_look_b   (bus.rd_b_addr),
        .o_busy     (w_sb_busy),
        .o_busy_a   (w_busy_a),
        .o_busy_b   (w_busy_b)
    );

    // A requester's req is ignored during its own grant cycle (turnaround).
    assign w_rd_eff  = bus.rd_req  && !r_rd_gnt;
    assign w_wb0_eff = bus.wb0_req && !r_wb0_gnt;
    assign w_wb1_eff = bus.wb1_req && !r_wb1_gnt;
    assign w_rd_elig = w_rd_eff && !w_busy_a && !w_busy_b;

    // pick the owner of the next port cycle
    always_comb begin
        w_win = GNT_NONE;
        if (w_rd_elig && (r_starve_cnt == SC_MAX)) begin
            w_win = GNT_RD;
        end else if (w_wb0_eff && w_wb1_eff) begin
            w_win = r_rr_ptr ? GNT_WB1 : GNT_WB0;
        end else if (w_wb0_eff) begin
            w_win = GNT_WB0;
        end else if (w_wb1_eff) begin
            w_win = GNT_WB1;
        end else if (w_rd_elig) begin
            w_win = GNT_RD;
        end
    end

    // count arbitrations an eligible read has lost to writes
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (!bus.rd_req || (w_win == GNT_RD)) begin
            w_starve_next = '0;
        end else if (w_rd_elig && gnt_is_write(w_win) && (r_starve_cnt != SC_MAX)) begin
            w_starve_next = r_starve_cnt + 1'b1;
        end
    end

    // grant pulses, read-valid pipeline, round-robin pointer and starvation counter
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_gnt     <= 1'b0;
            r_wb0_gnt    <= 1'b0;
            r_wb1_gnt    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_rd_gnt     <= (w_win == GNT_RD);
            r_wb0_gnt    <= (w_win == GNT_WB0);
            r_wb1_gnt    <= (w_win == GNT_WB1);
            r_rd_valid   <= r_rd_gnt;
            r_starve_cnt <= w_starve_next;
            if (w_win == GNT_WB0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_win == GNT_WB1) begin
                r_rr_ptr <= 1'b0;
            end
        end
    end

    // bank port registers; addresses and data hold while the port is idle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_hab     <= 1'b0;
            r_sel_c_a <= '0;
            r_sel_b   <= '0;
            r_wc      <= '0;
        end else begin
            r_hab <= gnt_is_write(w_win);
            case (w_win)
                GNT_RD: begin
                    r_sel_c_a <= bus.rd_a_addr;
                    r_sel_b   <= bus.rd_b_addr;
                end
                GNT_WB0: begin
                    r_sel_c_a <= bus.wb0_addr;
                    r_wc      <= bus.wb0_data;
                end
                GNT_WB1: begin
                    r_sel_c_a <= bus.wb1_addr;
                    r_wc      <= bus.wb1_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_gnt         = r_rd_gnt;
    assign bus.wb0_gnt        = r_wb0_gnt;
    assign bus.wb1_gnt        = r_wb1_gnt;
    assign bus.rd_valid       = r_rd_valid;
    assign bus.rf_hab_escrita = r_hab;
    assign bus.rf_sel_c_a     = r_sel_c_a;
    assign bus.rf_sel_b       = r_sel_b;
    assign bus.rf_wc          = r_wc;
    assign bus.sb_busy        = w_sb_busy;

    // bank outputs pass straight through, forced to zero while reset is held
    assign bus.rd_a_data = i_reset ? '0 : bus.rf_a_q;
    assign bus.rd_b_data = i_reset ? '0 : bus.rf_b_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level model (expected memory contents,
// pending-writer set, per-requester wait bound).
module tb_regfile_port_arbiter;
    import regfile_port_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    regfile_port_arbiter_if bus ();

    regfile_port_arbiter dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    logic [31:0] bank_mem [16];
    logic [31:0] ref_mem  [16];

    function automatic logic [31:0] init_val(int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h11;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural bank: loads its initial pattern while reset is held, then
    // writes or reads on the falling edge. B holds during write cycles.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) bank_mem[i] <= init_val(i);
        end else if (bus.rf_hab_escrita) begin
            bank_mem[bus.rf_sel_c_a] <= bus.rf_wc;
            bus.rf_a_q <= bus.rf_wc;
        end else begin
            bus.rf_a_q <= bank_mem[bus.rf_sel_c_a];
            bus.rf_b_q <= bank_mem[bus.rf_sel_b];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_req = 0; bus.rd_a_addr = 0; bus.rd_b_addr = 0;
        bus.wb0_req = 0; bus.wb0_addr = 0; bus.wb0_data = 0;
        bus.wb1_req = 0; bus.wb1_addr = 0; bus.wb1_data = 0;
        bus.sb_set = 0; bus.sb_set_addr = 0;
    endtask

    task automatic init_ref();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic check_all_zero(string tag);
        n_checks++;
        if ({bus.rd_gnt, bus.rd_valid, bus.wb0_gnt, bus.wb1_gnt, bus.rf_hab_escrita} !== 5'b0) begin
            n_errors++;
            $display("FAIL %s_ctrl: gnt/valid/hab=%b required 00000", tag,
                     {bus.rd_gnt, bus.rd_valid, bus.wb0_gnt, bus.wb1_gnt, bus.rf_hab_escrita});
        end
        n_checks++;
        if (bus.sb_busy !== 16'h0) begin
            n_errors++;
            $display("FAIL %s_busy: sb_busy=%h required 0000", tag, bus.sb_busy);
        end
        n_checks++;
        if ({bus.rf_sel_c_a, bus.rf_sel_b, bus.rf_wc, bus.rd_a_data, bus.rd_b_data} !== 104'h0) begin
            n_errors++;
            $display("FAIL %s_port: sel_c_a=%h sel_b=%h wc=%h a=%h b=%h required all 0", tag,
                     bus.rf_sel_c_a, bus.rf_sel_b, bus.rf_wc, bus.rd_a_data, bus.rd_b_data);
        end
    endtask

    task automatic test_reset();
        init_ref();
        repeat (2) tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        // make some state, then reset in the middle of a read grant cycle
        bus.sb_set = 1; bus.sb_set_addr = 4'd2;
        bus.rd_req = 1; bus.rd_a_addr = 4'd3; bus.rd_b_addr = 4'd5;
        tick();
        bus.sb_set = 0;
        n_checks++;
        if (bus.rd_gnt !== 1'b1 || bus.rf_sel_c_a !== 4'd3 || bus.sb_busy[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_setup: rd_gnt=%b sel_c_a=%h busy2=%b required 1 3 1",
                     bus.rd_gnt, bus.rf_sel_c_a, bus.sb_busy[2]);
        end
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        bus.rd_req = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({bus.rd_valid, bus.rd_gnt, bus.wb0_gnt, bus.wb1_gnt} !== 4'b0) begin
                n_errors++;
                $display("FAIL reset_dropped: valid/gnts=%b required 0000",
                         {bus.rd_valid, bus.rd_gnt, bus.wb0_gnt, bus.wb1_gnt});
            end
        end
        $display("txn reset mid-read done");
    endtask

    task automatic test_single_read();
        bus.rd_req = 1; bus.rd_a_addr = 4'd1; bus.rd_b_addr = 4'd2;
        tick();
        n_checks++;
        if (bus.rd_gnt !== 1'b1 || bus.rf_sel_c_a !== 4'd1 || bus.rf_sel_b !== 4'd2 ||
            bus.rf_hab_escrita !== 1'b0) begin
            n_errors++;
            $display("FAIL read_gnt: gnt=%b sel_c_a=%h sel_b=%h hab=%b required 1 1 2 0",
                     bus.rd_gnt, bus.rf_sel_c_a, bus.rf_sel_b, bus.rf_hab_escrita);
        end
        bus.rd_req = 0;
        tick();
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_a_data !== ref_mem[1] || bus.rd_b_data !== ref_mem[2]) begin
            n_errors++;
            $display("FAIL read_data: valid=%b a=%h b=%h required 1 %h %h",
                     bus.rd_valid, bus.rd_a_data, bus.rd_b_data, ref_mem[1], ref_mem[2]);
        end
        tick();
        n_checks++;
        if (bus.rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL read_valid_pulse: valid=%b required 0", bus.rd_valid);
        end
        $display("txn read a=1 b=2");
    endtask

    task automatic test_dual_write();
        bus.wb0_req = 1; bus.wb0_addr = 4'd4; bus.wb0_data = 32'hAAAA_0000;
        bus.wb1_req = 1; bus.wb1_addr = 4'd6; bus.wb1_data = 32'h0000_0055;
        tick();
        n_checks++;
        if (bus.wb0_gnt !== 1'b1 || bus.wb1_gnt !== 1'b0 || bus.rf_hab_escrita !== 1'b1 ||
            bus.rf_sel_c_a !== 4'd4 || bus.rf_wc !== 32'hAAAA_0000) begin
            n_errors++;
            $display("FAIL dual_wb0: g0=%b g1=%b hab=%b sel=%h wc=%h required 1 0 1 4 aaaa0000",
                     bus.wb0_gnt, bus.wb1_gnt, bus.rf_hab_escrita, bus.rf_sel_c_a, bus.rf_wc);
        end
        bus.wb0_req = 0; ref_mem[4] = 32'hAAAA_0000;
        tick();
        n_checks++;
        if (bus.wb1_gnt !== 1'b1 || bus.wb0_gnt !== 1'b0 || bus.rf_hab_escrita !== 1'b1 ||
            bus.rf_sel_c_a !== 4'd6 || bus.rf_wc !== 32'h0000_0055 || bus.rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL dual_wb1: g0=%b g1=%b hab=%b sel=%h wc=%h valid=%b required 0 1 1 6 00000055 0",
                     bus.wb0_gnt, bus.wb1_gnt, bus.rf_hab_escrita, bus.rf_sel_c_a, bus.rf_wc, bus.rd_valid);
        end
        bus.wb1_req = 0; ref_mem[6] = 32'h0000_0055;
        tick();
        n_checks++;
        if (bus.rf_hab_escrita !== 1'b0 || bus.wb0_gnt !== 1'b0 || bus.wb1_gnt !== 1'b0 || bus.rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL dual_idle: hab=%b g0=%b g1=%b valid=%b required 0 0 0 0",
                     bus.rf_hab_escrita, bus.wb0_gnt, bus.wb1_gnt, bus.rd_valid);
        end
        bus.rd_req = 1; bus.rd_a_addr = 4'd4; bus.rd_b_addr = 4'd6;
        tick();
        bus.rd_req = 0;
        tick();
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_a_data !== 32'hAAAA_0000 || bus.rd_b_data !== 32'h0000_0055) begin
            n_errors++;
            $display("FAIL dual_readback: valid=%b a=%h b=%h required 1 aaaa0000 00000055",
                     bus.rd_valid, bus.rd_a_data, bus.rd_b_data);
        end
        $display("txn dual write r4 r6 and readback");
    endtask

    task automatic test_scoreboard_stall();
        bus.sb_set = 1; bus.sb_set_addr = 4'd7;
        tick();
        bus.sb_set = 0;
        n_checks++;
        if (bus.sb_busy[7] !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_set: busy7=%b required 1", bus.sb_busy[7]);
        end
        bus.rd_req = 1; bus.rd_a_addr = 4'd7; bus.rd_b_addr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.rd_gnt !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold: rd_gnt=%b required 0 (cycle %0d)", bus.rd_gnt, i);
            end
        end
        bus.wb1_req = 1; bus.wb1_addr = 4'd7; bus.wb1_data = 32'h1234_5678;
        tick();
        n_checks++;
        if (bus.wb1_gnt !== 1'b1 || bus.sb_busy[7] !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_write: wb1_gnt=%b busy7=%b required 1 1", bus.wb1_gnt, bus.sb_busy[7]);
        end
        bus.wb1_req = 0; ref_mem[7] = 32'h1234_5678;
        tick();
        n_checks++;
        if (bus.sb_busy[7] !== 1'b0 || bus.rd_gnt !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_clear: busy7=%b rd_gnt=%b required 0 0", bus.sb_busy[7], bus.rd_gnt);
        end
        tick();
        n_checks++;
        if (bus.rd_gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release: rd_gnt=%b required 1", bus.rd_gnt);
        end
        bus.rd_req = 0;
        tick();
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_a_data !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL stall_data: valid=%b a=%h required 1 12345678", bus.rd_valid, bus.rd_a_data);
        end
        $display("txn scoreboard stall on r7");
    endtask

    task automatic test_starvation();
        gnt_src_e exp_seq [9];
        gnt_src_e obs;
        exp_seq = '{GNT_WB0, GNT_WB1, GNT_WB0, GNT_RD, GNT_WB1, GNT_WB0, GNT_WB1, GNT_WB0, GNT_RD};
        bus.rd_req  = 1; bus.rd_a_addr = 4'd0; bus.rd_b_addr = 4'd1;
        bus.wb0_req = 1; bus.wb0_addr = 4'd10; bus.wb0_data = 32'h0A0A_0A0A;
        bus.wb1_req = 1; bus.wb1_addr = 4'd11; bus.wb1_data = 32'h0B0B_0B0B;
        for (int i = 0; i < 9; i++) begin
            tick();
            obs = bus.rd_gnt ? GNT_RD : bus.wb0_gnt ? GNT_WB0 : bus.wb1_gnt ? GNT_WB1 : GNT_NONE;
            n_checks++;
            if (obs !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL starve_seq[%0d]: grant=%s required %s", i, obs.name(), exp_seq[i].name());
            end
            if (i == 4) begin
                n_checks++;
                if (bus.rd_valid !== 1'b1 || bus.rd_a_data !== ref_mem[0] || bus.rd_b_data !== ref_mem[1]) begin
                    n_errors++;
                    $display("FAIL starve_data: valid=%b a=%h b=%h required 1 %h %h",
                             bus.rd_valid, bus.rd_a_data, bus.rd_b_data, ref_mem[0], ref_mem[1]);
                end
            end
        end
        idle_inputs();
        ref_mem[10] = 32'h0A0A_0A0A;
        ref_mem[11] = 32'h0B0B_0B0B;
        tick();
        tick();
        $display("txn starvation pattern with 3 lost arbitrations");
    endtask

    task automatic test_collision();
        bus.wb0_req = 1; bus.wb0_addr = 4'd9; bus.wb0_data = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if (bus.wb0_gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL collide_gnt: wb0_gnt=%b required 1", bus.wb0_gnt);
        end
        bus.wb0_req = 0; ref_mem[9] = 32'hDEAD_BEEF;
        bus.sb_set = 1; bus.sb_set_addr = 4'd9;
        tick();
        bus.sb_set = 0;
        n_checks++;
        if (bus.sb_busy[9] !== 1'b1) begin
            n_errors++;
            $display("FAIL collide_set_wins: busy9=%b required 1", bus.sb_busy[9]);
        end
        bus.wb1_req = 1; bus.wb1_addr = 4'd9; bus.wb1_data = 32'h0000_0909;
        tick();
        bus.wb1_req = 0; ref_mem[9] = 32'h0000_0909;
        tick();
        n_checks++;
        if (bus.sb_busy[9] !== 1'b0) begin
            n_errors++;
            $display("FAIL collide_cleanup: busy9=%b required 0", bus.sb_busy[9]);
        end
        $display("txn set/clear collision on r9");
    endtask

    task automatic test_random();
        logic [15:0] exp_busy, old_busy;
        bit          prev_set, prev_wgnt, rd_pend, val_pending, set_used;
        logic [3:0]  prev_set_addr, prev_waddr, rd_a, rd_b;
        logic [31:0] val_a, val_b;
        int          rd_wait;
        bit          wp [2];
        bit          wg [2];
        logic [3:0]  wa [2];
        logic [31:0] wd [2];
        int          ww [2];
        int          ngnt;

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        init_ref();
        exp_busy = '0; prev_set = 0; prev_wgnt = 0; prev_set_addr = 0; prev_waddr = 0;
        rd_pend = 0; rd_a = 0; rd_b = 0; rd_wait = 0; val_pending = 0; val_a = 0; val_b = 0;
        for (int k = 0; k < 2; k++) begin wp[k] = 0; wa[k] = 0; wd[k] = 0; ww[k] = 0; end

        for (int cyc = 0; cyc < 500; cyc++) begin
            tick();
            old_busy = exp_busy;
            if (prev_wgnt) exp_busy[prev_waddr] = 1'b0;
            if (prev_set)  exp_busy[prev_set_addr] = 1'b1;
            n_checks++;
            if (bus.sb_busy !== exp_busy) begin
                n_errors++;
                $display("FAIL rnd_busy@%0d: sb_busy=%h required %h", cyc, bus.sb_busy, exp_busy);
            end
            n_checks++;
            if (val_pending) begin
                if (bus.rd_valid !== 1'b1 || bus.rd_a_data !== val_a || bus.rd_b_data !== val_b) begin
                    n_errors++;
                    $display("FAIL rnd_rdata@%0d: valid=%b a=%h b=%h required 1 %h %h",
                             cyc, bus.rd_valid, bus.rd_a_data, bus.rd_b_data, val_a, val_b);
                end
            end else if (bus.rd_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL rnd_valid@%0d: rd_valid=%b required 0", cyc, bus.rd_valid);
            end
            val_pending = 0;
            wg[0] = bus.wb0_gnt;
            wg[1] = bus.wb1_gnt;
            ngnt = int'(bus.rd_gnt) + int'(wg[0]) + int'(wg[1]);
            n_checks++;
            if (ngnt > 1) begin
                n_errors++;
                $display("FAIL rnd_onehot@%0d: %0d grants in one cycle required at most 1", cyc, ngnt);
            end
            prev_wgnt = 0;
            if (bus.rd_gnt === 1'b1) begin
                n_checks++;
                if (!rd_pend || old_busy[rd_a] || old_busy[rd_b] || bus.rf_hab_escrita !== 1'b0 ||
                    bus.rf_sel_c_a !== rd_a || bus.rf_sel_b !== rd_b) begin
                    n_errors++;
                    $display("FAIL rnd_rgnt@%0d: pend=%b busyA=%b busyB=%b hab=%b sel=%h/%h required 1 0 0 0 %h/%h",
                             cyc, rd_pend, old_busy[rd_a], old_busy[rd_b], bus.rf_hab_escrita,
                             bus.rf_sel_c_a, bus.rf_sel_b, rd_a, rd_b);
                end
                $display("txn rd a=%0d b=%0d", rd_a, rd_b);
                val_pending = 1; val_a = ref_mem[rd_a]; val_b = ref_mem[rd_b];
                rd_pend = 0;
            end
            for (int k = 0; k < 2; k++) begin
                if (wg[k]) begin
                    n_checks++;
                    if (!wp[k] || bus.rf_hab_escrita !== 1'b1 || bus.rf_sel_c_a !== wa[k] || bus.rf_wc !== wd[k]) begin
                        n_errors++;
                        $display("FAIL rnd_wgnt%0d@%0d: pend=%b hab=%b sel=%h wc=%h required 1 1 %h %h",
                                 k, cyc, wp[k], bus.rf_hab_escrita, bus.rf_sel_c_a, bus.rf_wc, wa[k], wd[k]);
                    end
                    $display("txn wb%0d r%0d=%h", k, wa[k], wd[k]);
                    ref_mem[wa[k]] = wd[k];
                    prev_wgnt = 1; prev_waddr = wa[k];
                    wp[k] = 0;
                end
            end
            if (!wg[0] && !wg[1]) begin
                n_checks++;
                if (bus.rf_hab_escrita !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rnd_hab@%0d: hab=%b required 0", cyc, bus.rf_hab_escrita);
                end
            end
            if (rd_pend) begin
                rd_wait++;
                if (rd_wait > 64) begin
                    n_checks++; n_errors++;
                    $display("FAIL rnd_rd_wait@%0d: read r%0d/r%0d not granted in 64 cycles", cyc, rd_a, rd_b);
                    rd_pend = 0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (wp[k]) begin
                    ww[k]++;
                    if (ww[k] > 64) begin
                        n_checks++; n_errors++;
                        $display("FAIL rnd_wb%0d_wait@%0d: write not granted in 64 cycles", k, cyc);
                        wp[k] = 0;
                    end
                end
            end
            // new stimulus
            prev_set = 0;
            set_used = 0;
            if (cyc < 420) begin
                if (!rd_pend && ($urandom % 4 == 0)) begin
                    rd_pend = 1; rd_wait = 0;
                    rd_a = 4'($urandom_range(15, 0));
                    rd_b = 4'($urandom_range(15, 0));
                end
                for (int k = 0; k < 2; k++) begin
                    if (!wp[k] && ($urandom % 3 == 0)) begin
                        wp[k] = 1; ww[k] = 0;
                        wa[k] = 4'($urandom_range(15, 0));
                        wd[k] = $urandom;
                        if (!set_used) begin
                            set_used = 1; prev_set = 1; prev_set_addr = wa[k];
                        end
                    end
                end
            end
            bus.sb_set = prev_set; bus.sb_set_addr = prev_set_addr;
            bus.rd_req = rd_pend; bus.rd_a_addr = rd_a; bus.rd_b_addr = rd_b;
            bus.wb0_req = wp[0]; bus.wb0_addr = wa[0]; bus.wb0_data = wd[0];
            bus.wb1_req = wp[1]; bus.wb1_addr = wa[1]; bus.wb1_data = wd[1];
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_dual_write();
        test_scoreboard_stall();
        test_starvation();
        test_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
